sccb_init_seq: RTL



---
 rtl/sccb_init_pkg.sv | 31 +++
 rtl/axi4_lite_if.sv | 28 ++
 rtl/sccb_init_seq_ms_timer.sv | 31 +++
 rtl/sccb_init_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sccb_init_pkg.sv
// sccb_init_pkg: init-table entry layout, opcodes and decode helper shared by the init sequencer.
package sccb_init_pkg;
  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_DELAY  = 2'd1,
    OP_VERIFY = 2'd2,
    OP_END    = 2'd3
  } sccb_op_e;
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int RSV_MSB  = 29;
  localparam int RSV_LSB  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  typedef struct packed {
    sccb_op_e    op;
    logic [5:0]  rsvd;
    logic [15:0] addr;
    logic [7:0]  data;
  } sccb_init_entry_t;
  function automatic sccb_init_entry_t unpack_entry(input logic [31:0] w);
    sccb_init_entry_t e;
    e.op   = sccb_op_e'(w[OP_MSB:OP_LSB]);
    e.rsvd = w[RSV_MSB:RSV_LSB];
    e.addr = w[ADDR_MSB:ADDR_LSB];
    e.data = w[DATA_MSB:DATA_LSB];
    return e;
  endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite channel bundle between the init sequencer and the SCCB master register window.
interface axi4_lite_if #(parameter int ADDR_W = 32);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/sccb_init_seq_ms_timer.sv
// sccb_ms_timer: 1 ms prescaler driving a 16-bit millisecond down-counter.
module sccb_ms_timer #(
  parameter int CLK_FREQ = 74_250_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [15:0] ms_i,
  output logic        expired_o
);
  localparam int TICKS = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_ms;
  logic          w_tick;
  assign w_tick = r_pre == PW'(TICKS - 1);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (load_i) begin
      r_pre <= '0;
      r_ms  <= ms_i;
    end else if (r_ms != 16'd0) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_ms  <= w_tick ? r_ms - 16'd1 : r_ms;
    end
  end
  // Flag the final tick itself so the caller leaves on exactly N ms, not N ms + 1 cycle.
  assign expired_o = (r_ms == 16'd0) || (r_ms == 16'd1 && w_tick);
endmodule

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a sensor init table and replays it as AXI4-Lite writes, delays and
// read-back verifies against the SCCB master, reporting done/error and the failing entry.
module sccb_init_seq
  import sccb_init_pkg::*;
#(
  parameter int CLK_FREQ     = 74_250_000,
  parameter int TABLE_DEPTH  = 256,
  parameter int RESP_TIMEOUT = 1_000_000,
  parameter int AXI_ADDR_W   = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  output logic [$clog2(TABLE_DEPTH)-1:0] tbl_addr_o,
  input  logic [31:0]                    tbl_data_i,
  axi4_lite_if.master                    sccb_if,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [$clog2(TABLE_DEPTH)-1:0] err_idx_o,
  output logic [7:0]                     err_rdata_o
);
  localparam int IW  = $clog2(TABLE_DEPTH);
  localparam int TOW = $clog2(RESP_TIMEOUT + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP,
    S_DLY, S_NEXT, S_DONE, S_ERR
  } state_e;
  state_e            r_state;
  sccb_init_entry_t  r_entry;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_err_idx;
  logic [7:0]        r_err_rdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic [AXI_ADDR_W-1:0] r_awaddr;
  logic [AXI_ADDR_W-1:0] r_araddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [TOW-1:0]    r_tmo;
  sccb_init_entry_t  w_ent;
  logic              w_load;
  logic              w_expired;
  logic              w_tmo_hit;
  logic              w_aw_ok;
  logic              w_w_ok;
  logic [IW:0]       w_idx_inc;
  logic              w_wrap;
  logic              w_unused;
  assign w_ent     = unpack_entry(tbl_data_i);
  assign w_load    = (r_state == S_DECODE) && (w_ent.op == OP_DELAY) && (w_ent.addr != 16'd0);
  assign w_tmo_hit = r_tmo == TOW'(RESP_TIMEOUT - 1);
  assign w_aw_ok   = !r_awvalid || sccb_if.awready;
  assign w_w_ok    = !r_wvalid || sccb_if.wready;
  assign w_idx_inc = {1'b0, r_idx} + 1'b1;
  assign w_wrap    = w_idx_inc == (IW + 1)'(TABLE_DEPTH);
  assign w_unused  = ^{r_entry.op, r_entry.rsvd, r_entry.addr, sccb_if.bresp, sccb_if.rresp,
                       sccb_if.rdata[31:8]};
  sccb_ms_timer #(.CLK_FREQ(CLK_FREQ)) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (w_load),
    .ms_i      (w_ent.addr),
    .expired_o (w_expired)
  );
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_entry     <= '0;
      r_idx       <= '0;
      r_err_idx   <= '0;
      r_err_rdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_tmo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_entry <= w_ent;
          case (w_ent.op)
            OP_WRITE: begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= AXI_ADDR_W'(w_ent.addr);
              r_wdata   <= {24'd0, w_ent.data};
              r_wstrb   <= 4'b0001;
              r_state   <= S_WR_REQ;
            end
            OP_DELAY: r_state <= (w_ent.addr == 16'd0) ? S_NEXT : S_DLY;
            OP_VERIFY: begin
              r_arvalid <= 1'b1;
              r_araddr  <= AXI_ADDR_W'(w_ent.addr);
              r_state   <= S_RD_REQ;
            end
            default: begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          endcase
        end
        S_WR_REQ: begin
          if (r_awvalid && sccb_if.awready) r_awvalid <= 1'b0;
          if (r_wvalid && sccb_if.wready) r_wvalid <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_tmo    <= '0;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (sccb_if.bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_NEXT;
          end else if (w_tmo_hit) begin
            r_bready  <= 1'b0;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
            r_state   <= S_ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RD_REQ: if (sccb_if.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_tmo     <= '0;
          r_state   <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (sccb_if.rvalid) begin
            r_rready <= 1'b0;
            if (sccb_if.rdata[7:0] == r_entry.data) begin
              r_state <= S_NEXT;
            end else begin
              r_err       <= 1'b1;
              r_err_idx   <= r_idx;
              r_err_rdata <= sccb_if.rdata[7:0];
              r_state     <= S_ERR;
            end
          end else if (w_tmo_hit) begin
            r_rready  <= 1'b0;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
            r_state   <= S_ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DLY: if (w_expired) r_state <= S_NEXT;
        S_NEXT: begin
          r_idx   <= w_idx_inc[IW-1:0];
          r_done  <= w_wrap;
          r_state <= w_wrap ? S_DONE : S_FETCH;
        end
        S_DONE, S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign tbl_addr_o      = r_idx;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign err_idx_o       = r_err_idx;
  assign err_rdata_o     = r_err_rdata;
  assign sccb_if.awvalid = r_awvalid;
  assign sccb_if.awaddr  = r_awaddr;
  assign sccb_if.wvalid  = r_wvalid;
  assign sccb_if.wdata   = r_wdata;
  assign sccb_if.wstrb   = r_wstrb;
  assign sccb_if.bready  = r_bready;
  assign sccb_if.arvalid = r_arvalid;
  assign sccb_if.araddr  = r_araddr;
  assign sccb_if.rready  = r_rready;
endmodule
